// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN sequencer: commands, ALU opcodes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rpn_pkg;

   localparam logic [1:0] CMD_PUSH  = 2'b00;
   localparam logic [1:0] CMD_OP    = 2'b01;
   localparam logic [1:0] CMD_DROP  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Unary ops consume only the top entry and rewrite it in place.
   function automatic logic is_unary(input logic [2:0] op);
      return op == OP_NOT;
   endfunction

   function automatic logic is_legal(input logic [2:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rpn_pilha.sv
// Operand stack storage: one write port, entry counter, combinational top/second reads.
// Latency: writes and count changes visible the cycle after the enable.
// Backpressure: none; the controller guarantees pointers stay within 0..DEPTH.
// Ports: core_clk/rst (sync, active-high), clr zeroes everything,
//        wr_en/wr_idx/wr_dat write one entry, cnt_inc/cnt_dec move the count,
//        count = valid entries, top_dat = entry[count-1], nxt_dat = entry[count-2] (0 if absent).
module rpn_pilha
   import rpn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int PTR_W = 3
) (
   input  logic             core_clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             cnt_inc,
   input  logic             cnt_dec,
   output logic [PTR_W-1:0] count,
   output logic [WIDTH-1:0] top_dat,
   output logic [WIDTH-1:0] nxt_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge core_clk) begin
      if (rst || clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         count <= '0;
      end else begin
         // Index decode by compare keeps the pointer width independent of DEPTH.
         if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wr_idx == PTR_W'(i)) mem[i] <= wr_dat;
            end
         end
         if (cnt_inc && !cnt_dec)      count <= count + PTR_W'(1);
         else if (cnt_dec && !cnt_inc) count <= count - PTR_W'(1);
      end
   end

   always_comb begin
      top_dat = '0;
      nxt_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == PTR_W'(i + 1)) top_dat = mem[i];
         if ((i + 2 <= DEPTH) && (count == PTR_W'(i + 2))) nxt_dat = mem[i];
      end
   end

endmodule

// File: rtl/rpn_controlador.sv
// RPN sequencer: owns the operand stack, feeds the ALU, writes results back, strobes the carry register.
// Latency: PUSH/DROP/CLEAR 1 cycle; OP 3 edges from accept to result on TOP (IDLE -> EXEC -> WB -> IDLE).
// Backpressure: READY low during EXEC and WB; IN_VALID in those cycles is dropped, not queued.
// Ports: CLOCK, RESET (sync, active-high); IN_VALID/IN_CMD/IN_DATA/IN_OPCODE command in, READY out;
//        ALU_A/ALU_B/ALU_OP to the ALU, ALU_RESULT back (ALU_COUT goes straight to the carry register);
//        CARRY_EN strobe, TOP/COUNT stack view, ERR_OVF/ERR_UNF/ERR_OPC error flags.
// Build option RPN_ERR_STICKY_EN: error flags hold until CLEAR/RESET instead of pulsing one cycle.
module rpn_controlador
   import rpn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int PTR_W = 3
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             IN_VALID,
   input  logic [1:0]       IN_CMD,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic [2:0]       IN_OPCODE,
   output logic             READY,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [2:0]       ALU_OP,
   input  logic [WIDTH-1:0] ALU_RESULT,
   input  logic             ALU_COUT,
   output logic             CARRY_EN,
   output logic [WIDTH-1:0] TOP,
   output logic [PTR_W-1:0] COUNT,
   output logic             ERR_OVF,
   output logic             ERR_UNF,
   output logic             ERR_OPC
);

   state_t           state, state_nxt;

   logic             accept;
   logic             full, empty, enough, op_go;
   logic [PTR_W-1:0] need;

   logic             stk_clr, stk_wr_en, stk_inc, stk_dec;
   logic [PTR_W-1:0] stk_wr_idx;
   logic [WIDTH-1:0] stk_wr_dat;
   logic [WIDTH-1:0] stk_top, stk_nxt;

   logic             ovf_set, unf_set, opc_set, err_clr;

   // Carry-out bypasses this block entirely; it is wired to the carry register D input.
   logic             alu_cout_unused;
   assign alu_cout_unused = ALU_COUT;

   assign accept = IN_VALID && READY;
   assign full   = (COUNT == PTR_W'(DEPTH));
   assign empty  = (COUNT == '0);
   assign need   = is_unary(IN_OPCODE) ? PTR_W'(1) : PTR_W'(2);
   assign enough = (COUNT >= need);
   assign op_go  = accept && (IN_CMD == CMD_OP) && is_legal(IN_OPCODE) && enough;

   // ---- FSM: state register ----
   always_ff @(posedge CLOCK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (op_go) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs and stack control ----
   always_comb begin
      READY      = (state == ST_IDLE);
      CARRY_EN   = (state == ST_WB);
      stk_clr    = 1'b0;
      stk_wr_en  = 1'b0;
      stk_wr_idx = '0;
      stk_wr_dat = '0;
      stk_inc    = 1'b0;
      stk_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (IN_CMD)
                  CMD_PUSH: begin
                     if (!full) begin
                        stk_wr_en  = 1'b1;
                        stk_wr_idx = COUNT;
                        stk_wr_dat = IN_DATA;
                        stk_inc    = 1'b1;
                     end
                  end
                  CMD_DROP:  stk_dec = !empty;
                  CMD_CLEAR: stk_clr = 1'b1;
                  default:   ;
               endcase
            end
         end
         ST_WB: begin
            // Binary ops collapse two entries into one at the old second slot.
            stk_wr_en  = 1'b1;
            stk_wr_dat = ALU_RESULT;
            if (is_unary(ALU_OP)) begin
               stk_wr_idx = COUNT - PTR_W'(1);
            end else begin
               stk_wr_idx = COUNT - PTR_W'(2);
               stk_dec    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ALU operands are captured at accept and held through EXEC and WB.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ALU_A  <= '0;
         ALU_B  <= '0;
         ALU_OP <= '0;
      end else if (op_go) begin
         ALU_OP <= IN_OPCODE;
         ALU_B  <= stk_top;
         ALU_A  <= is_unary(IN_OPCODE) ? '0 : stk_nxt;
      end
   end

   // ---- error flags ----
   always_comb begin
      ovf_set = accept && (IN_CMD == CMD_PUSH) && full;
      // Illegal opcode wins over underflow, so underflow only counts for legal ops.
      opc_set = accept && (IN_CMD == CMD_OP) && !is_legal(IN_OPCODE);
      unf_set = accept && (((IN_CMD == CMD_DROP) && empty) ||
                           ((IN_CMD == CMD_OP) && is_legal(IN_OPCODE) && !enough));
      err_clr = accept && (IN_CMD == CMD_CLEAR);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ERR_OVF <= 1'b0;
         ERR_UNF <= 1'b0;
         ERR_OPC <= 1'b0;
      end else begin
`ifdef RPN_ERR_STICKY_EN
         if (err_clr) begin
            ERR_OVF <= 1'b0;
            ERR_UNF <= 1'b0;
            ERR_OPC <= 1'b0;
         end else begin
            ERR_OVF <= ERR_OVF | ovf_set;
            ERR_UNF <= ERR_UNF | unf_set;
            ERR_OPC <= ERR_OPC | opc_set;
         end
`else
         // Pulse mode: a flag is high only in the cycle after its command; CLEAR sets none.
         ERR_OVF <= ovf_set && !err_clr;
         ERR_UNF <= unf_set && !err_clr;
         ERR_OPC <= opc_set && !err_clr;
`endif
      end
   end

   rpn_pilha #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_pilha (
      .core_clk (CLOCK),
      .rst      (RESET),
      .clr      (stk_clr),
      .wr_en    (stk_wr_en),
      .wr_idx   (stk_wr_idx),
      .wr_dat   (stk_wr_dat),
      .cnt_inc  (stk_inc),
      .cnt_dec  (stk_dec),
      .count    (COUNT),
      .top_dat  (stk_top),
      .nxt_dat  (stk_nxt)
   );

   assign TOP = stk_top;

endmodule

// File: tb/tb_rpn_controlador.sv
// Bench for rpn_controlador: directed scenarios then random commands against a queue-based stack model.
// Latency: commands issued on falling edges, outputs sampled on falling edges.
// Backpressure: random IN_VALID noise is driven while the DUT is busy and must be ignored.
module tb_rpn_controlador;
   import rpn_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int PTR_W = 3;

   logic             CLOCK = 1'b0;
   logic             RESET = 1'b1;
   logic             IN_VALID = 1'b0;
   logic [1:0]       IN_CMD = 2'b00;
   logic [WIDTH-1:0] IN_DATA = '0;
   logic [2:0]       IN_OPCODE = 3'b000;
   logic             READY;
   logic [WIDTH-1:0] ALU_A, ALU_B;
   logic [2:0]       ALU_OP;
   logic [WIDTH-1:0] ALU_RESULT;
   logic             ALU_COUT;
   logic             CARRY_EN;
   logic [WIDTH-1:0] TOP;
   logic [PTR_W-1:0] COUNT;
   logic             ERR_OVF, ERR_UNF, ERR_OPC;

   int n_chk = 0;
   int n_err = 0;
   int n_carry_seen = 0;
   int n_ops_exp = 0;

   logic [7:0] q[$];
   logic [2:0] m_err = 3'b000;

   always #5 CLOCK = ~CLOCK;

   rpn_controlador #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_CMD(IN_CMD),
      .IN_DATA(IN_DATA), .IN_OPCODE(IN_OPCODE), .READY(READY),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
      .ALU_RESULT(ALU_RESULT), .ALU_COUT(ALU_COUT), .CARRY_EN(CARRY_EN),
      .TOP(TOP), .COUNT(COUNT),
      .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF), .ERR_OPC(ERR_OPC)
   );

   // Reference ALU: {carry/borrow, result}.
   function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~b};
         default: return 9'd0;
      endcase
   endfunction

   assign {ALU_COUT, ALU_RESULT} = alu_ref(ALU_OP, ALU_A, ALU_B);

   always @(negedge CLOCK) if (CARRY_EN) n_carry_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_top();
      return (q.size() == 0) ? 8'h00 : q[q.size() - 1];
   endfunction

   task automatic chk_stack(input string tag);
      chk({tag, "_count"}, 32'(COUNT), 32'(q.size()));
      chk({tag, "_top"},   32'(TOP),   32'(m_top()));
   endtask

   // Issue one command, advance the model, and check every visible effect.
   task automatic issue(input logic [1:0] cmd, input logic [7:0] dat, input logic [2:0] opc, input bit noise);
      int         n;
      bit         exec;
      logic [2:0] e;
      logic [7:0] a, b, r;
      logic       c;
      n    = q.size();
      exec = 0;
      e    = 3'b000;
      a    = 8'h00;
      b    = 8'h00;
      r    = 8'h00;
      c    = 1'b0;
      case (cmd)
         CMD_PUSH:  if (n < DEPTH) q.push_back(dat); else e[2] = 1'b1;
         CMD_DROP:  if (n >= 1) void'(q.pop_back()); else e[1] = 1'b1;
         CMD_CLEAR: q.delete();
         default: begin
            if (opc > 3'd5)                        e[0] = 1'b1;
            else if (n < ((opc == 3'd5) ? 1 : 2))  e[1] = 1'b1;
            else                                   exec = 1;
         end
      endcase
      if (exec) begin
         b = q[n - 1];
         a = (opc == 3'd5) ? 8'h00 : q[n - 2];
         {c, r} = alu_ref(opc, a, b);
         if (opc == 3'd5) q[n - 1] = r;
         else begin
            void'(q.pop_back());
            q[n - 2] = r;
         end
         n_ops_exp++;
      end
`ifdef RPN_ERR_STICKY_EN
      if (cmd == CMD_CLEAR) m_err = 3'b000;
      m_err = m_err | e;
`else
      m_err = e;
`endif

      @(negedge CLOCK);
      chk("ready_before", 32'(READY), 32'd1);
      IN_VALID  = 1'b1;
      IN_CMD    = cmd;
      IN_DATA   = dat;
      IN_OPCODE = opc;
      @(negedge CLOCK);
      IN_VALID = 1'b0;
      if (exec) begin
         if (noise) begin
            IN_VALID  = 1'b1;
            IN_CMD    = 2'($urandom);
            IN_DATA   = 8'($urandom);
            IN_OPCODE = 3'($urandom);
         end
         chk("exec_ready", 32'(READY), 32'd0);
         chk("exec_carry_en", 32'(CARRY_EN), 32'd0);
         chk("exec_alu_a", 32'(ALU_A), 32'(a));
         chk("exec_alu_b", 32'(ALU_B), 32'(b));
         chk("exec_alu_op", 32'(ALU_OP), 32'(opc));
         @(negedge CLOCK);
         chk("wb_ready", 32'(READY), 32'd0);
         chk("wb_carry_en", 32'(CARRY_EN), 32'd1);
         chk("wb_cout", 32'(ALU_COUT), 32'(c));
         @(negedge CLOCK);
         IN_VALID = 1'b0;
         chk("done_ready", 32'(READY), 32'd1);
         chk("done_carry_en", 32'(CARRY_EN), 32'd0);
         chk_stack("op");
         chk("op_err", 32'({ERR_OVF, ERR_UNF, ERR_OPC}), 32'(m_err));
      end else begin
         chk("cmd_carry_en", 32'(CARRY_EN), 32'd0);
         chk_stack("cmd");
         chk("cmd_err", 32'({ERR_OVF, ERR_UNF, ERR_OPC}), 32'(m_err));
         @(negedge CLOCK);
`ifndef RPN_ERR_STICKY_EN
         m_err = 3'b000;
`endif
         chk("err_after", 32'({ERR_OVF, ERR_UNF, ERR_OPC}), 32'(m_err));
         chk("idle_carry_en", 32'(CARRY_EN), 32'd0);
      end
   endtask

   initial begin
      // Reset state
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK);
      chk("rst_ready", 32'(READY), 32'd1);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_top", 32'(TOP), 32'd0);
      chk("rst_alu", 32'({ALU_A, ALU_B, ALU_OP}), 32'd0);
      chk("rst_carry_en", 32'(CARRY_EN), 32'd0);
      chk("rst_err", 32'({ERR_OVF, ERR_UNF, ERR_OPC}), 32'd0);
      RESET = 1'b0;

      // 0F + F1 wraps to 00 with carry out
      issue(CMD_PUSH, 8'h0F, 3'd0, 0);
      issue(CMD_PUSH, 8'hF1, 3'd0, 0);
      issue(CMD_OP,   8'h00, OP_ADD, 0);
      chk("add_top", 32'(TOP), 32'h00);
      chk("add_count", 32'(COUNT), 32'd1);

      // Unary NOT rewrites the top in place
      issue(CMD_CLEAR, 8'h00, 3'd0, 0);
      issue(CMD_PUSH,  8'hA5, 3'd0, 0);
      issue(CMD_OP,    8'h00, OP_NOT, 1);
      chk("not_top", 32'(TOP), 32'h5A);
      chk("not_count", 32'(COUNT), 32'd1);

      // Overflow on the fifth push
      issue(CMD_CLEAR, 8'h00, 3'd0, 0);
      issue(CMD_PUSH, 8'h11, 3'd0, 0);
      issue(CMD_PUSH, 8'h22, 3'd0, 0);
      issue(CMD_PUSH, 8'h33, 3'd0, 0);
      issue(CMD_PUSH, 8'h44, 3'd0, 0);
      issue(CMD_PUSH, 8'h55, 3'd0, 0);
      chk("ovf_top", 32'(TOP), 32'h44);
      chk("ovf_count", 32'(COUNT), 32'd4);

      // Underflow cases
      issue(CMD_CLEAR, 8'h00, 3'd0, 0);
      issue(CMD_DROP,  8'h00, 3'd0, 0);
      issue(CMD_PUSH,  8'h07, 3'd0, 0);
      issue(CMD_OP,    8'h00, OP_SUB, 0);

      // Illegal opcode with two operands present
      issue(CMD_PUSH, 8'h09, 3'd0, 0);
      issue(CMD_OP,   8'h00, 3'b111, 0);
      chk("opc_count", 32'(COUNT), 32'd2);
      issue(CMD_OP,   8'h00, OP_SUB, 1);

      // Reset while in EXEC discards the operation
      issue(CMD_PUSH, 8'h3C, 3'd0, 0);
      @(negedge CLOCK);
      IN_VALID  = 1'b1;
      IN_CMD    = CMD_OP;
      IN_OPCODE = OP_ADD;
      @(negedge CLOCK);
      IN_VALID = 1'b0;
      chk("rexec_ready", 32'(READY), 32'd0);
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET = 1'b0;
      q.delete();
      m_err = 3'b000;
      chk("rexec_ready_after", 32'(READY), 32'd1);
      chk("rexec_carry_en", 32'(CARRY_EN), 32'd0);
      chk_stack("rexec");
      chk("rexec_alu_b", 32'(ALU_B), 32'd0);
      @(negedge CLOCK);
      chk("rexec_carry_en2", 32'(CARRY_EN), 32'd0);

      // Random commands against the model
      for (int i = 0; i < 400; i++) begin
         int          r;
         logic [1:0]  cmd;
         r   = int'($urandom_range(0, 99));
         cmd = (r < 40) ? CMD_PUSH : (r < 75) ? CMD_OP : (r < 90) ? CMD_DROP : CMD_CLEAR;
         issue(cmd, 8'($urandom), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      end

      @(negedge CLOCK);
      chk("carry_pulses", 32'(n_carry_seen), 32'(n_ops_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/rpn_controlador.md
Name: rpn_controlador

Overview:
- Sequencing stage directly upstream of the ALU datapath and its carry-in register.
- Holds the RPN operand stack and accepts push/operate/drop/clear commands.
- Presents operands and opcode to the ALU, writes the result back onto the stack, and pulses the enable of the 1-bit carry register so it captures ALU carry-out exactly once per executed operation.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DEPTH, 4, stack entries; DEPTH >= 2.
- PTR_W, 3, pointer width; must hold values 0..DEPTH.

Ports:
- CLOCK  in  1  single system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  command strobe; sampled only when READY=1.
- IN_CMD  in  2  command: 00 PUSH, 01 OP, 10 DROP, 11 CLEAR.
- IN_DATA  in  WIDTH  operand for PUSH.
- IN_OPCODE  in  3  ALU operation for OP: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (unary); 110 and 111 are illegal.
- READY  out  1  high when a command can be accepted.
- ALU_A  out  WIDTH  second-from-top entry (binary ops); zero for unary ops.
- ALU_B  out  WIDTH  top of stack.
- ALU_OP  out  3  registered opcode.
- ALU_RESULT  in  WIDTH  combinational ALU result.
- ALU_COUT  in  1  ALU carry/borrow out; routed externally to the carry register D input.
- CARRY_EN  out  1  one-cycle enable for the carry register.
- TOP  out  WIDTH  current top of stack; 0 when empty.
- COUNT  out  PTR_W  number of valid entries.
- ERR_OVF  out  1  push attempted while full.
- ERR_UNF  out  1  OP or DROP attempted with too few entries.
- ERR_OPC  out  1  illegal opcode.

Behaviour:
- Reset: state IDLE, COUNT=0, all entries=0, READY=1, ALU_A=ALU_B=0, ALU_OP=0, CARRY_EN=0, all ERR_* outputs=0. Reset overrides any in-flight operation; the partial operation is discarded.
- States: IDLE, EXEC, WB.
- IDLE accepts a command when IN_VALID & READY:
  - PUSH with COUNT<DEPTH: entry[COUNT]=IN_DATA, COUNT+1. Stays in IDLE; 1-cycle latency.
  - PUSH with COUNT=DEPTH: stack unchanged, ERR_OVF set.
  - DROP with COUNT>=1: COUNT-1. With COUNT=0: ERR_UNF set.
  - CLEAR: COUNT=0, entries zeroed, error flags cleared.
  - OP, legal opcode with enough operands (binary: COUNT>=2; NOT: COUNT>=1): latch ALU_OP, drive ALU_A/ALU_B, go to EXEC.
  - OP with an illegal opcode: ERR_OPC set, no state change.
  - OP with too few operands: ERR_UNF set, no state change. Illegal opcode takes precedence over underflow.
- EXEC: READY=0; ALU inputs held stable for one full cycle; go to WB.
- WB: READY=0. CARRY_EN=1 for this cycle only. Binary op: entry[COUNT-2]=ALU_RESULT, COUNT-1. NOT: entry[COUNT-1]=ALU_RESULT. Return to IDLE.
- Operation latency: accept edge to result visible on TOP = 3 rising edges; READY returns high the cycle after WB.
- IN_VALID while READY=0 is ignored and not queued.
- CARRY_EN is never asserted outside WB, including on errors, PUSH, DROP, and CLEAR.
- TOP is combinational from entry[COUNT-1].
- Pointer arithmetic is unsigned, PTR_W bits; COUNT never exceeds DEPTH and never wraps.

Optional Feature:
- Macro: RPN_ERR_STICKY_EN.
- Defined: ERR_* flags are sticky; cleared only by CLEAR or RESET.
- Undefined: each ERR_* flag is a single-cycle pulse in the cycle after the offending command; flags are zero at all other times.

Decomposition:
- Shared package rpn_pkg holds:
  - command encodings (CMD_PUSH, CMD_OP, CMD_DROP, CMD_CLEAR);
  - opcode encodings (OP_ADD .. OP_NOT);
  - state encoding (ST_IDLE, ST_EXEC, ST_WB);
  - an is_unary function.
- One natural sub-module: rpn_pilha (stack storage with write port, pointer, and TOP read). The FSM and error logic stay in rpn_controlador.

Test Plan:
- RESET; PUSH 8'h0F, PUSH 8'hF1, OP ADD with ALU model returning 8'h00 and COUT=1 -> CARRY_EN high exactly one cycle, 3 edges after acceptance; TOP=8'h00; COUNT=1; READY low for 2 cycles.
- PUSH 8'hA5, OP NOT -> TOP=8'h5A, COUNT unchanged at 1, ALU_A=0, one CARRY_EN pulse.
- Five PUSHes with DEPTH=4 -> COUNT=4, ERR_OVF asserted, TOP equals the fourth pushed value.
- Empty stack: DROP -> ERR_UNF asserted. COUNT=1: OP SUB -> ERR_UNF asserted. CARRY_EN never asserted in either case.
- OP with opcode 3'b111 and COUNT=2 -> ERR_OPC only, stack intact. Check the flag persists (macro defined) versus pulses for one cycle (macro undefined).
- Assert RESET during EXEC -> next cycle IDLE, COUNT=0, CARRY_EN=0. IN_VALID pulses during EXEC/WB are ignored.
